// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, multi-read register file that zeroes itself with a
// DEPTH-cycle sweep after reset or on a clr request before accepting traffic.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_run;
  logic              w_we0;
  logic              w_we1;

  assign w_run = r_state == S_RUN;
  assign ready = w_run;
  // A clr edge discards the writes it shares a cycle with, so they never bypass either.
  assign w_we0 = w_run && we0 && !clr && !(ZERO_REG != 0 && wa0 == '0);
  assign w_we1 = w_run && we1 && !clr && !(ZERO_REG != 0 && wa1 == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (!w_run) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_RUN;
    end else if (clr) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end

  // Storage has no reset; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!w_run) r_mem[r_clr_cnt] <= '0;
    if (w_we0) r_mem[wa0] <= wd0;
    if (w_we1) r_mem[wa1] <= wd1;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = ra[k*ADDR_W +: ADDR_W];
    assign rd[k*DATA_W +: DATA_W] =
      (!w_run || (ZERO_REG != 0 && w_ra == '0))  ? '0  :
      (BYPASS != 0 && w_we1 && wa1 == w_ra)      ? wd1 :
      (BYPASS != 0 && w_we0 && wa0 == w_ra)      ? wd0 :
                                                   r_mem[w_ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors against two instances sharing stimulus,
// one with default parameters and one with BYPASS=0, ZERO_REG=0.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n, clr, we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd_a, rd_b;
  logic        ready_a, ready_b;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_a),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd_a)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_b),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic sweep_wait(input string tag);
    for (int e = 1; e < 32; e++) begin
      step();
      chk({tag, " ready_a low"}, 32'(ready_a), 0);
      chk({tag, " ready_b low"}, 32'(ready_b), 0);
    end
    step();
    chk({tag, " ready_a high"}, 32'(ready_a), 1);
    chk({tag, " ready_b high"}, 32'(ready_b), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra = {5'd3, 5'd9};
    repeat (3) step();
    chk("rst ready_a", 32'(ready_a), 0);
    chk("rst rd_a", rd_a[31:0], 0);
    chk("rst rd_b", rd_b[63:32], 0);
    rst_n = 1'b1;
    sweep_wait("boot");
    #1;
    chk("boot rd_a0", rd_a[31:0], 0);
    chk("boot rd_b1", rd_b[63:32], 0);

    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra = {5'd9, 5'd5};
    #1;
    chk("byp a", rd_a[31:0], 32'hDEADBEEF);
    chk("nobyp b", rd_b[31:0], 0);
    step();
    idle();
    #1;
    chk("wr5 a", rd_a[31:0], 32'hDEADBEEF);
    chk("wr5 b", rd_b[31:0], 32'hDEADBEEF);

    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22;
    ra = {5'd7, 5'd7};
    #1;
    chk("coll byp a0", rd_a[31:0], 32'h22);
    chk("coll byp a1", rd_a[63:32], 32'h22);
    chk("coll old b", rd_b[31:0], 0);
    step();
    idle();
    #1;
    chk("coll a", rd_a[31:0], 32'h22);
    chk("coll b", rd_b[63:32], 32'h22);

    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    #1;
    chk("zr wcyc a", rd_a[31:0], 0);
    chk("zr wcyc b", rd_b[31:0], 0);
    step();
    idle();
    #1;
    chk("zr after a", rd_a[63:32], 0);
    chk("zr after b", rd_b[63:32], 32'hFFFFFFFF);

    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
      step();
    end
    idle();
    ra = {5'd31, 5'd12};
    #1;
    chk("fill a12", rd_a[31:0], 12);
    chk("fill a31", rd_a[63:32], 31);
    chk("fill b12", rd_b[31:0], 12);

    clr = 1'b1; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000ABCD; ra = {5'd3, 5'd3};
    #1;
    chk("clr nobyp a", rd_a[31:0], 3);
    step();
    idle();
    #1;
    chk("clr ready_a", 32'(ready_a), 0);
    chk("clr rd_a", rd_a[31:0], 0);
    chk("clr rd_b", rd_b[63:32], 0);
    sweep_wait("clr");
    for (int i = 0; i < 32; i++) begin
      ra = {5'(i), 5'(i)};
      #1;
      chk("swept a", rd_a[31:0], 0);
      chk("swept b", rd_b[63:32], 0);
    end

    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
    step();
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    ra = {5'd9, 5'd9};
    #1;
    chk("midrst ready_a", 32'(ready_a), 0);
    chk("midrst rd_a", rd_a[31:0], 0);
    chk("midrst rd_b", rd_b[63:32], 0);
    step();
    rst_n = 1'b1;
    sweep_wait("rerst");
    #1;
    chk("rerst rd_a", rd_a[31:0], 0);
    chk("rerst rd_b", rd_b[63:32], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
